// File: rtl/jt51_exp2lin_dac.sv
// Serial floating-point (10-bit mantissa, 3-bit exponent) to 16-bit linear stereo converter.
// Optional build macro JT51_EXP2LIN_ROUND_EN adds a half-LSB fill below the decoded value.
module jt51_exp2lin_dac #(
    parameter int unsigned SH_POL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               so,
    input  logic               sh1,
    input  logic               sh2,
    output logic signed [15:0] left,
    output logic signed [15:0] right,
    output logic               left_vld,
    output logic               right_vld,
    output logic               frame_err
);

    localparam logic L_ACT = (SH_POL != 0);

    logic [1:0]  w_act;
    logic        w_both;
    logic [12:0] r_sr   [2];
    logic [3:0]  r_cnt  [2];
    logic [1:0]  r_bad;
    logic [1:0]  r_prev;
    logic [1:0]  r_pend;
    logic        r_epend;

    assign w_act[0] = (sh1 == L_ACT);
    assign w_act[1] = (sh2 == L_ACT);
    assign w_both   = &w_act;

    function automatic logic [15:0] f_decode(input logic [12:0] fr);
        logic [2:0]  e;
        logic [15:0] lin;
        e   = (fr[12:10] == 3'd0) ? 3'd1 : fr[12:10];
        lin = {{6{fr[9]}}, fr[9:0]} << (e - 3'd1);
`ifdef JT51_EXP2LIN_ROUND_EN
        if (e >= 3'd2) begin
            lin[{1'b0, e} - 4'd2] = 1'b1;
        end
`endif
        return lin;
    endfunction

    // Frame capture: frames are LSB first, so new bits enter at the top and move down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                r_sr[c]  <= '0;
                r_cnt[c] <= '0;
            end
            r_bad   <= '0;
            r_prev  <= '0;
            r_pend  <= '0;
            r_epend <= 1'b0;
        end else begin
            r_pend  <= '0;
            r_epend <= 1'b0;
            if (cen) begin
                for (int c = 0; c < 2; c++) begin
                    r_prev[c] <= w_act[c];
                    if (w_both) begin
                        r_bad[c] <= 1'b1;
                        if (!r_prev[c]) begin
                            r_cnt[c] <= '0;
                        end
                    end else if (w_act[c]) begin
                        if (!r_prev[c]) begin
                            r_sr[c]  <= {so, 12'd0};
                            r_cnt[c] <= 4'd1;
                            r_bad[c] <= 1'b0;
                        end else begin
                            r_sr[c] <= {so, r_sr[c][12:1]};
                            if (r_cnt[c] != 4'd15) begin
                                r_cnt[c] <= r_cnt[c] + 4'd1;
                            end
                        end
                    end
                    if (r_prev[c] && !w_act[c]) begin
                        if (r_cnt[c] == 4'd13 && !r_bad[c]) begin
                            r_pend[c] <= 1'b1;
                        end else begin
                            r_epend <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Output stage runs one clk behind end of frame; r_sr is still intact at that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left      <= '0;
            right     <= '0;
            left_vld  <= 1'b0;
            right_vld <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            left_vld  <= r_pend[0];
            right_vld <= r_pend[1];
            frame_err <= r_epend;
            if (r_pend[0]) begin
                left <= f_decode(r_sr[0]);
            end
            if (r_pend[1]) begin
                right <= f_decode(r_sr[1]);
            end
        end
    end

endmodule

// File: tb/tb_jt51_exp2lin_dac.sv
// Directed bench for jt51_exp2lin_dac: hand-computed frames, discard cases, reset and an encoder sweep.
module tb_jt51_exp2lin_dac;

    localparam logic ACT = 1'b1;
`ifdef JT51_EXP2LIN_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cen = 1'b0;
    logic               so  = 1'b0;
    logic               sh1 = ~ACT;
    logic               sh2 = ~ACT;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic               left_vld;
    logic               right_vld;
    logic               frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_err_pulses = 0;
    logic [15:0] m_left  = '0;
    logic [15:0] m_right = '0;

    jt51_exp2lin_dac #(.SH_POL(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .so        (so),
        .sh1       (sh1),
        .sh2       (sh2),
        .left      (left),
        .right     (right),
        .left_vld  (left_vld),
        .right_vld (right_vld),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) n_err_pulses++;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, want);
        end
    endtask

    task automatic set_strobes(input bit a1, input bit a2);
        sh1 = a1 ? ACT : ~ACT;
        sh2 = a2 ? ACT : ~ACT;
    endtask

    // Shift nbits of fr on channel ch, then drop the strobe; returns just after the end-of-frame edge.
    task automatic send_frame(input int ch, input logic [15:0] fr, input int nbits, input bit gap);
        for (int i = 0; i < nbits; i++) begin
            if (gap) begin
                cen = 1'b0;
                so  = ~fr[i];
                set_strobes(ch == 0, ch == 1);
                @(negedge clk);
            end
            cen = 1'b1;
            so  = fr[i];
            set_strobes(ch == 0, ch == 1);
            @(negedge clk);
        end
        cen = 1'b1;
        so  = 1'b0;
        set_strobes(1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic expect_update(input int ch, input logic [15:0] want, input string tag);
        check_eq({tag, " vld_early"}, {15'd0, (ch == 0) ? left_vld : right_vld}, 16'd0);
        @(negedge clk);
        if (ch == 0) begin
            m_left = want;
            check_eq({tag, " left_vld"}, {15'd0, left_vld}, 16'd1);
            check_eq({tag, " right_vld"}, {15'd0, right_vld}, 16'd0);
        end else begin
            m_right = want;
            check_eq({tag, " right_vld"}, {15'd0, right_vld}, 16'd1);
            check_eq({tag, " left_vld"}, {15'd0, left_vld}, 16'd0);
        end
        check_eq({tag, " left"}, left, m_left);
        check_eq({tag, " right"}, right, m_right);
        check_eq({tag, " frame_err"}, {15'd0, frame_err}, 16'd0);
        @(negedge clk);
        check_eq({tag, " vld_after"}, {14'd0, left_vld, right_vld}, 16'd0);
    endtask

    task automatic expect_discard(input string tag);
        check_eq({tag, " err_early"}, {15'd0, frame_err}, 16'd0);
        @(negedge clk);
        check_eq({tag, " frame_err"}, {15'd0, frame_err}, 16'd1);
        check_eq({tag, " vld"}, {14'd0, left_vld, right_vld}, 16'd0);
        check_eq({tag, " left"}, left, m_left);
        check_eq({tag, " right"}, right, m_right);
        @(negedge clk);
        check_eq({tag, " err_after"}, {15'd0, frame_err}, 16'd0);
    endtask

    // Reference lin2exp encoder: smallest exponent whose mantissa fits 10 signed bits.
    task automatic encode(input logic [15:0] lin, output logic [15:0] fr, output logic [15:0] want);
        int v, e, m;
        v = int'($signed(lin));
        e = 1;
        while (e < 7 && ((v >>> (e - 1)) > 511 || (v >>> (e - 1)) < -512)) e++;
        m    = v >>> (e - 1);
        fr   = {3'd0, 3'(e), 10'(m)};
        want = lin & ~16'((1 << (e - 1)) - 1);
        if (RND && e >= 2) want = want | 16'(1 << (e - 2));
    endtask

    initial begin
        logic [15:0] fr, want, lin;
        int          errs0;
        logic [15:0] bnd [10];
        bnd = '{16'h0000, 16'h7FFF, 16'h8000, 16'h01FF, 16'h0200,
                16'hFE00, 16'hFDFF, 16'hFFFF, 16'h3FFF, 16'hC000};

        @(negedge clk);
        @(negedge clk);
        check_eq("reset left", left, 16'h0000);
        check_eq("reset right", right, 16'h0000);
        check_eq("reset flags", {13'd0, left_vld, right_vld, frame_err}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        send_frame(0, {3'd0, 3'd1, 10'h1FF}, 13, 1'b0);
        expect_update(0, 16'h01FF, "L 1FF e1");
        send_frame(1, {3'd0, 3'd7, 10'h200}, 13, 1'b0);
        expect_update(1, RND ? 16'h8020 : 16'h8000, "R 200 e7");
        send_frame(0, {3'd0, 3'd3, 10'h155}, 13, 1'b1);
        expect_update(0, RND ? 16'h0556 : 16'h0554, "L 155 e3 cen gaps");
        send_frame(1, {3'd0, 3'd0, 10'h3FF}, 13, 1'b0);
        expect_update(1, 16'hFFFF, "R 3FF e0");
        send_frame(0, {3'd0, 3'd4, 10'h001}, 13, 1'b0);
        expect_update(0, RND ? 16'h000C : 16'h0008, "L 001 e4");

        send_frame(0, {3'd0, 3'd2, 10'h0AA}, 12, 1'b0);
        expect_discard("L 12 bits");
        send_frame(0, 16'h3FFF, 14, 1'b0);
        expect_discard("L 14 bits");

        // Both strobes active for one edge mid-frame.
        errs0 = n_err_pulses;
        cen = 1'b1;
        for (int i = 0; i < 6; i++) begin
            so = i[0];
            set_strobes(1'b1, 1'b0);
            @(negedge clk);
        end
        set_strobes(1'b1, 1'b1);
        @(negedge clk);
        set_strobes(1'b0, 1'b0);
        @(negedge clk);
        expect_discard("both strobes");
        repeat (3) @(negedge clk);
        check_eq("both strobes err pulses", 16'(n_err_pulses - errs0), 16'd1);

        // Reset in the middle of a frame.
        for (int i = 0; i < 6; i++) begin
            so = 1'b1;
            set_strobes(1'b1, 1'b0);
            @(negedge clk);
        end
        rst = 1'b1;
        set_strobes(1'b0, 1'b0);
        #1;
        check_eq("midreset left", left, 16'h0000);
        check_eq("midreset right", right, 16'h0000);
        check_eq("midreset flags", {13'd0, left_vld, right_vld, frame_err}, 16'd0);
        m_left  = '0;
        m_right = '0;
        errs0 = n_err_pulses;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post reset no err", 16'(n_err_pulses - errs0), 16'd0);
        send_frame(1, {3'd0, 3'd2, 10'h0FF}, 13, 1'b0);
        expect_update(1, RND ? 16'h01FF : 16'h01FE, "R 0FF e2 after reset");
        send_frame(0, {3'd0, 3'd1, 10'h1FF}, 13, 1'b0);
        expect_update(0, 16'h01FF, "L 1FF after reset");

        for (int i = 0; i < 10; i++) begin
            encode(bnd[i], fr, want);
            send_frame(i % 2, fr, 13, 1'b0);
            expect_update(i % 2, want, $sformatf("bnd %04h", bnd[i]));
        end
        for (int i = 0; i < 256; i++) begin
            lin = 16'(i * 257 + 3);
            encode(lin, fr, want);
            send_frame(i % 2, fr, 13, 1'b0);
            expect_update(i % 2, want, $sformatf("sweep %04h", lin));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
